// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// over a shared datapath and one req/ack memory port. Optional ILLEGAL_OP_TRAP_EN adds trap_o.
module multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       Op_i,
  input  logic             Zero_i,
  input  logic             mem_ack_i,
  output logic             MemReq_o,
  output logic             MemWrite_o,
  output logic             IorD_o,
  output logic             IRWrite_o,
  output logic             PCWrite_o,
  output logic             PCSrc_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [1:0]       ALUOp_o,
  output logic             RegDst_o,
  output logic             MemtoReg_o,
  output logic             RegWrite_o,
  output logic             busy_o,
  output logic             err_o,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic             trap_o,
`endif
  output logic [CNT_W-1:0] instret_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // Wait counter only needs to reach MEM_TIMEOUT-1; the limit cycle itself decides.
  localparam int              WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit              TMO_EN    = (MEM_TIMEOUT > 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_ERROR, S_TRAP
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_st;
  logic              retire;
  logic              tmo_hit;

  assign tmo_hit = TMO_EN && (wait_cnt == WAIT_LAST);
  assign busy_o  = (state != S_IDLE);
  assign err_o   = (state == S_ERROR);
`ifdef ILLEGAL_OP_TRAP_EN
  assign trap_o  = (state == S_TRAP);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      instret_o <= '0;
    end else begin
      state <= state_nxt;
      if (mem_st && !mem_ack_i) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                      wait_cnt <= '0;
      if (retire) instret_o <= instret_o + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_st     = 1'b0;
    retire     = 1'b0;
    MemReq_o   = 1'b0;
    MemWrite_o = 1'b0;
    IorD_o     = 1'b0;
    IRWrite_o  = 1'b0;
    PCWrite_o  = 1'b0;
    PCSrc_o    = 1'b0;
    ALUSrcA_o  = 1'b0;
    ALUSrcB_o  = 2'b00;
    ALUOp_o    = 2'b00;
    RegDst_o   = 1'b0;
    MemtoReg_o = 1'b0;
    RegWrite_o = 1'b0;
    case (state)
      S_IDLE: if (start_i) state_nxt = S_FETCH;
      S_FETCH: begin
        mem_st    = 1'b1;
        MemReq_o  = 1'b1;
        ALUSrcB_o = 2'b01;
        ALUOp_o   = 2'b01;
        if (mem_ack_i) begin
          IRWrite_o = 1'b1;
          PCWrite_o = 1'b1;
          state_nxt = S_DECODE;
        end else if (tmo_hit) begin
          state_nxt = S_ERROR;
        end
      end
      S_DECODE: begin
        // Branch target is computed speculatively here so BRANCH only compares.
        ALUSrcB_o = 2'b11;
        ALUOp_o   = 2'b01;
        case (Op_i)
          OP_RTYPE:      state_nxt = S_EXEC_R;
          OP_ADDI:       state_nxt = S_EXEC_I;
          OP_LW, OP_SW:  state_nxt = S_MEM_ADDR;
          OP_BEQ:        state_nxt = S_BRANCH;
`ifdef ILLEGAL_OP_TRAP_EN
          default:       state_nxt = S_TRAP;
`else
          default: begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
          end
`endif
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA_o = 1'b1;
        state_nxt = S_WB_R;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        ALUOp_o   = 2'b01;
        if (state == S_EXEC_I) state_nxt = S_WB_I;
        else                   state_nxt = (Op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD, S_MEM_WR: begin
        mem_st     = 1'b1;
        MemReq_o   = 1'b1;
        IorD_o     = 1'b1;
        MemWrite_o = (state == S_MEM_WR);
        if (mem_ack_i) begin
          state_nxt = (state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
          retire    = (state == S_MEM_WR);
        end else if (tmo_hit) begin
          state_nxt = S_ERROR;
        end
      end
      S_WB_R, S_WB_I, S_WB_MEM: begin
        RegWrite_o = 1'b1;
        RegDst_o   = (state == S_WB_R);
        MemtoReg_o = (state == S_WB_MEM);
        retire     = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = 2'b10;
        PCSrc_o   = 1'b1;
        PCWrite_o = Zero_i;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = state;
    endcase
  end

endmodule
